// File: rtl/read_if_buffer.sv
// read_if_buffer: fetches num_beats read beats over AXI in bursts into a first-word fall-through FIFO.
// Latency: start -> ARVALID in 2 cycles when the FIFO has room; RDATA -> RD_BUF_DATA in 1 cycle on an empty FIFO.
// Backpressure: a burst is requested only once it fits entirely; RREADY drops while full; consumer drains with RD_BUF_POP.
// Optional RRESP error flag (RRESP input, rd_error output) is built when READ_IF_BUFFER_RRESP_CHECK_EN is defined.

module read_if_buffer_fifo #(
    parameter int WIDTH      = 256,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop on an empty FIFO and a push on a full FIFO are dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; head contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module read_if_buffer #(
    parameter int DATA_WIDTH      = 256,
    parameter int FIFO_ADDR_WIDTH = 5,
    parameter int BURST_LEN       = 16,
    parameter int AXI_ADDR_WIDTH  = 32
) (
    input  logic                      ACLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]               num_beats,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]                ARLEN,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic                      RVALID,
    input  logic                      RLAST,
`ifdef READ_IF_BUFFER_RRESP_CHECK_EN
    input  logic [1:0]                RRESP,
    output logic                      rd_error,
`endif
    output logic                      RREADY,
    output logic                      RD_BUF_EMPTY,
    input  logic                      RD_BUF_POP,
    output logic [DATA_WIDTH-1:0]     RD_BUF_DATA,
    output logic                      done
);
    localparam int DEPTH      = 2**FIFO_ADDR_WIDTH;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AR_REQ = 2'd1,
        R_DATA = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state;
    logic [15:0]              remaining;
    logic [15:0]              burst_size;
    logic [16:0]              free_entries;
    logic                     burst_fits;
    logic [FIFO_ADDR_WIDTH:0] fifo_count;
    logic                     fifo_full;
    logic                     r_fire;
    logic [31:0]              burst_bytes;

    // Never request more than the FIFO can absorb, so R beats of an accepted burst always find room.
    assign burst_size   = (remaining > 16'(BURST_LEN)) ? 16'(BURST_LEN) : remaining;
    assign free_entries = 17'(DEPTH) - 17'(fifo_count);
    assign burst_fits   = (free_entries >= {1'b0, burst_size});
    assign burst_bytes  = ({24'd0, ARLEN} + 32'd1) * 32'(BEAT_BYTES);

    // RREADY is combinational so it drops in the very cycle the FIFO becomes full.
    assign RREADY = (state == R_DATA) && !fifo_full;
    assign r_fire = RVALID && RREADY;

    read_if_buffer_fifo #(
        .WIDTH      (DATA_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (RESET),
        .push      (r_fire),
        .push_data (RDATA),
        .pop       (RD_BUF_POP),
        .head      (RD_BUF_DATA),
        .empty     (RD_BUF_EMPTY),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Transfer sequencing: one outstanding burst at a time, address/length held stable until accepted.
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            state     <= IDLE;
            remaining <= '0;
            ARADDR    <= '0;
            ARLEN     <= '0;
            ARVALID   <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (r_fire && (remaining != 16'd0)) remaining <= remaining - 16'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        ARADDR    <= base_addr;
                        remaining <= num_beats;
                        state     <= (num_beats == 16'd0) ? DONE : AR_REQ;
                    end
                end
                AR_REQ: begin
                    if (ARVALID) begin
                        if (ARREADY) begin
                            ARVALID <= 1'b0;
                            ARADDR  <= ARADDR + AXI_ADDR_WIDTH'(burst_bytes);
                            state   <= R_DATA;
                        end
                    end else if (burst_fits) begin
                        // Free space only grows in this state, so a registered request stays valid.
                        ARVALID <= 1'b1;
                        ARLEN   <= 8'(burst_size - 16'd1);
                    end
                end
                R_DATA: begin
                    if (r_fire && RLAST) begin
                        // remaining still holds the pre-decrement count on this beat.
                        state <= (remaining <= 16'd1) ? DONE : AR_REQ;
                    end
                end
                DONE: begin
                    if (RD_BUF_EMPTY) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef READ_IF_BUFFER_RRESP_CHECK_EN
    // Sticky error flag: any accepted beat with a non-OKAY response; a new transfer clears it.
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            rd_error <= 1'b0;
        end else if (start && (state == IDLE)) begin
            rd_error <= 1'b0;
        end else if (r_fire && (RRESP != 2'b00)) begin
            rd_error <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_read_if_buffer.sv
`timescale 1ns/1ps
module tb_read_if_buffer;
    localparam int DW = 256;
    localparam int AW = 32;

    logic          ACLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   num_beats = '0;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [DW-1:0] RDATA = '0;
    logic          RVALID = 1'b0;
    logic          RLAST = 1'b0;
    logic          RREADY;
    logic          RD_BUF_EMPTY;
    logic          RD_BUF_POP = 1'b0;
    logic [DW-1:0] RD_BUF_DATA;
    logic          done;
`ifdef READ_IF_BUFFER_RRESP_CHECK_EN
    logic [1:0]    RRESP = 2'b00;
    logic          rd_error;
    int            err_beat = -1;
`endif

    read_if_buffer dut (
        .ACLK(ACLK), .RESET(RESET), .start(start), .base_addr(base_addr), .num_beats(num_beats),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST),
`ifdef READ_IF_BUFFER_RRESP_CHECK_EN
        .RRESP(RRESP), .rd_error(rd_error),
`endif
        .RREADY(RREADY), .RD_BUF_EMPTY(RD_BUF_EMPTY), .RD_BUF_POP(RD_BUF_POP),
        .RD_BUF_DATA(RD_BUF_DATA), .done(done)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] sb[$];
    ar_t           ar_exp[$];

    logic ar_ready_en = 1'b1;
    logic slave_flush = 1'b0;
    int   pause_at = -1;
    int   beats_acc = 0;
    int   beats_left = 0;
    int   seq = 1;
    int   pop_budget = 0;
    int   pops_done = 0;
    logic pop_force = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI slave: decisions at negedge take effect on the following posedge.
    always @(negedge ACLK) begin
        ar_t e;
        if (slave_flush) begin
            beats_left = 0;
            RVALID = 1'b0;
            RLAST = 1'b0;
        end else begin
            if (beats_left > 0 && beats_acc != pause_at) begin
                RVALID = 1'b1;
                RDATA = {8{seq}};
                RLAST = (beats_left == 1);
`ifdef READ_IF_BUFFER_RRESP_CHECK_EN
                RRESP = (beats_acc == err_beat) ? 2'd2 : 2'd0;
`endif
                if (RREADY === 1'b1) begin
                    sb.push_back(RDATA);
                    seq++;
                    beats_acc++;
                    beats_left--;
                end
            end else begin
                RVALID = 1'b0;
                RLAST = 1'b0;
            end
            ARREADY = ar_ready_en;
            if (ARVALID === 1'b1 && ARREADY) begin
                check("ar_expected", DW'(ar_exp.size() != 0), DW'(1));
                if (ar_exp.size() != 0) begin
                    e = ar_exp.pop_front();
                    check("araddr", DW'(ARADDR), DW'(e.addr));
                    check("arlen", DW'(ARLEN), DW'(e.len));
                end
                beats_left = int'(ARLEN) + 1;
            end
        end
    end

    // Consumer: pops while budget remains, checking each head against the scoreboard.
    always @(negedge ACLK) begin
        if (pop_budget > 0 && RD_BUF_EMPTY === 1'b0) begin
            check("sb_has_entry", DW'(sb.size() != 0), DW'(1));
            if (sb.size() != 0) check("rd_data", RD_BUF_DATA, sb.pop_front());
            RD_BUF_POP = 1'b1;
            pop_budget--;
            pops_done++;
        end else begin
            RD_BUF_POP = pop_force;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [15:0] nb);
        base_addr = a;
        num_beats = nb;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_pops(input int target, input string tag);
        for (int i = 0; i < 3000 && pops_done < target; i++) step();
        check(tag, DW'(pops_done), DW'(target));
    endtask

    task automatic wait_beats(input int target, input string tag);
        for (int i = 0; i < 3000 && beats_acc < target; i++) step();
        check(tag, DW'(beats_acc), DW'(target));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && done !== 1'b1; i++) step();
        check(tag, DW'(done), DW'(1));
    endtask

    initial begin
        int b0;
        int p0;
        // Reset state
        step(3);
        check("rst_arvalid", DW'(ARVALID), DW'(0));
        check("rst_rready", DW'(RREADY), DW'(0));
        check("rst_empty", DW'(RD_BUF_EMPTY), DW'(1));
        check("rst_done", DW'(done), DW'(0));
        check("rst_araddr", DW'(ARADDR), DW'(0));
        check("rst_arlen", DW'(ARLEN), DW'(0));
`ifdef READ_IF_BUFFER_RRESP_CHECK_EN
        check("rst_rd_error", DW'(rd_error), DW'(0));
`endif
        RESET = 1'b0;
        step();

        // Zero-beat transfer: straight to done without any address request
        do_start(32'h3000, 16'd0);
        check("zero_arvalid", DW'(ARVALID), DW'(0));
        check("zero_done_early", DW'(done), DW'(0));
        step();
        check("zero_done", DW'(done), DW'(1));
        check("zero_arvalid2", DW'(ARVALID), DW'(0));
        step(2);
        check("zero_done_hold", DW'(done), DW'(1));

        // 40 beats with ARREADY always high: bursts 16,16,8 at 0x1000/0x1200/0x1400
        ar_exp.push_back('{addr: 32'h1000, len: 8'd15});
        ar_exp.push_back('{addr: 32'h1200, len: 8'd15});
        ar_exp.push_back('{addr: 32'h1400, len: 8'd7});
        p0 = pops_done;
        pop_budget = 40;
        do_start(32'h1000, 16'd40);
        check("s37_done_cleared", DW'(done), DW'(0));
        step(10);
        // Start while busy must be ignored
        base_addr = 32'hDEAD0;
        num_beats = 16'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_pops(p0 + 40, "s37_pops");
        wait_done("s37_done");
        check("s37_ar_all", DW'(ar_exp.size()), DW'(0));
        check("s37_empty", DW'(RD_BUF_EMPTY), DW'(1));

        // 64 beats, no pops: two bursts fill the FIFO, third waits for 16 free entries
        ar_exp.push_back('{addr: 32'h0000, len: 8'd15});
        ar_exp.push_back('{addr: 32'h0200, len: 8'd15});
        ar_exp.push_back('{addr: 32'h0400, len: 8'd15});
        ar_exp.push_back('{addr: 32'h0600, len: 8'd15});
        b0 = beats_acc;
        p0 = pops_done;
        do_start(32'h0000, 16'd64);
        wait_beats(b0 + 32, "s38_fill");
        step(5);
        check("s38_full_arvalid", DW'(ARVALID), DW'(0));
        check("s38_full_rready", DW'(RREADY), DW'(0));
        check("s38_full_beats", DW'(beats_acc), DW'(b0 + 32));
        ar_ready_en = 1'b0;
        pop_budget = 15;
        wait_pops(p0 + 15, "s38_pop15");
        step(3);
        check("s38_15free_arvalid", DW'(ARVALID), DW'(0));
        pop_budget = 1;
        wait_pops(p0 + 16, "s38_pop16");
        step(2);
        check("s38_16free_arvalid", DW'(ARVALID), DW'(1));
        check("s38_araddr", DW'(ARADDR), DW'(32'h0400));
        check("s38_arlen", DW'(ARLEN), DW'(15));
        step(3);
        check("s38_hold_arvalid", DW'(ARVALID), DW'(1));
        check("s38_hold_araddr", DW'(ARADDR), DW'(32'h0400));
        check("s38_hold_arlen", DW'(ARLEN), DW'(15));
        ar_ready_en = 1'b1;
        pop_budget = 48;
        wait_pops(p0 + 64, "s38_pops");
        wait_done("s38_done");

        // Pop on empty is ignored
        pop_force = 1'b1;
        step(2);
        pop_force = 1'b0;
        step();
        check("s40_pop_empty", DW'(RD_BUF_EMPTY), DW'(1));

        // Simultaneous push and pop at occupancy 31
        ar_exp.push_back('{addr: 32'h8000, len: 8'd15});
        ar_exp.push_back('{addr: 32'h8200, len: 8'd15});
        b0 = beats_acc;
        p0 = pops_done;
        pause_at = b0 + 31;
        do_start(32'h8000, 16'd32);
        wait_beats(b0 + 31, "s40_fill31");
        step(3);
        check("s40_occ31_nonempty", DW'(RD_BUF_EMPTY), DW'(0));
        pause_at = -1;
        pop_budget = 1;
        wait_pops(p0 + 1, "s40_simul_pop");
        step();
        check("s40_simul_beat", DW'(beats_acc), DW'(b0 + 32));
        pop_budget = 30;
        wait_pops(p0 + 31, "s40_pop30");
        step(2);
        check("s40_one_left", DW'(RD_BUF_EMPTY), DW'(0));
        pop_budget = 1;
        wait_pops(p0 + 32, "s40_pop_last");
        step(2);
        check("s40_empty_after", DW'(RD_BUF_EMPTY), DW'(1));
        wait_done("s40_done");

        // Reset after 5 beats of a burst
        ar_exp.push_back('{addr: 32'hA000, len: 8'd15});
        b0 = beats_acc;
        pause_at = b0 + 5;
        do_start(32'hA000, 16'd40);
        wait_beats(b0 + 5, "s41_five");
        step(2);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("s41_empty", DW'(RD_BUF_EMPTY), DW'(1));
        check("s41_arvalid", DW'(ARVALID), DW'(0));
        check("s41_rready", DW'(RREADY), DW'(0));
        check("s41_done", DW'(done), DW'(0));
        pause_at = -1;
        step(4);
        check("s41_refused_rready", DW'(RREADY), DW'(0));
        check("s41_refused_beats", DW'(beats_acc), DW'(b0 + 5));
        slave_flush = 1'b1;
        step();
        slave_flush = 1'b0;
        sb.delete();
        ar_exp.delete();
        ar_exp.push_back('{addr: 32'hB000, len: 8'd2});
        p0 = pops_done;
        pop_budget = 3;
        do_start(32'hB000, 16'd3);
        wait_pops(p0 + 3, "s41_restart_pops");
        wait_done("s41_restart_done");

`ifdef READ_IF_BUFFER_RRESP_CHECK_EN
        // Error response on beat 3: sticky until the next accepted start
        err_beat = beats_acc + 2;
        ar_exp.push_back('{addr: 32'hC000, len: 8'd3});
        p0 = pops_done;
        pop_budget = 4;
        do_start(32'hC000, 16'd4);
        check("s42_clear_start", DW'(rd_error), DW'(0));
        wait_pops(p0 + 4, "s42_pops");
        check("s42_err_set", DW'(rd_error), DW'(1));
        wait_done("s42_done");
        step(3);
        check("s42_err_sticky", DW'(rd_error), DW'(1));
        err_beat = -1;
        do_start(32'hD000, 16'd0);
        check("s42_err_cleared", DW'(rd_error), DW'(0));
        step(2);
`endif

        check("final_sb_empty", DW'(sb.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
